// File: rtl/reduce_sequencer_if.sv
// Bundle between the reduction controller and its environment: command,
// chunk handshake toward the adder tree, and the result handshake.
interface reduce_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 8
);
    logic                  start;
    logic [CNT_W-1:0]      num_chunks;
    logic                  busy;
    logic                  in_valid;
    logic                  in_ready;
    logic                  tree_enable;
    logic [DATA_WIDTH-1:0] tree_sum;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  done;

    // Handshakes: a chunk moves on a rising edge where in_valid && in_ready;
    // the result moves on a rising edge where out_valid && out_ready. A valid
    // source never withdraws or changes its payload while waiting for ready.
    modport slave (
        input  start, num_chunks, in_valid, tree_sum, out_ready,
        output busy, in_ready, tree_enable, out_valid, out_data, done
    );

    modport master (
        output start, num_chunks, in_valid, tree_sum, out_ready,
        input  busy, in_ready, tree_enable, out_valid, out_data, done
    );
endinterface

// File: rtl/reduce_sequencer.sv
// Controller for a LAYER-stage pipelined adder tree: feeds num_chunks chunks,
// tracks which tree outputs are real via a tag pipe, and accumulates them.
module reduce_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int LAYER      = 2,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    reduce_sequencer_if.slave bus,
    output logic [1:0]        dbg_state_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // Tag pattern when only the final chunk remains, sitting at the tree output.
    localparam logic [LAYER-1:0] TAG_LAST = LAYER'(1) << (LAYER - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LAYER-1:0]      tag_q, tag_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  done_q, done_d;
    logic                  tree_en;
    logic                  accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        acc_d   = acc_q;
        done_d  = 1'b0;

        // Tags move in lockstep with the tree stages, so only real chunks are summed.
        if (tree_en) begin
            tag_d = (tag_q << 1) | LAYER'(accept);
            if (tag_q[LAYER-1]) begin
                acc_d = acc_q + bus.tree_sum;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    tag_d = '0;
                    if (bus.num_chunks != '0) begin
                        cnt_d   = bus.num_chunks;
                        state_d = S_FEED;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_FEED: begin
                if (accept) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (tag_q == TAG_LAST) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tree_en         = (state_q == S_FEED) || (state_q == S_DRAIN);
        accept          = (state_q == S_FEED) && bus.in_valid;
        bus.busy        = (state_q != S_IDLE);
        bus.in_ready    = (state_q == S_FEED);
        bus.tree_enable = tree_en;
        bus.out_valid   = (state_q == S_OUT);
        bus.out_data    = acc_q;
        bus.done        = done_q;
        dbg_state_o     = state_q;
    end
endmodule

// File: doc/reduce_sequencer.md
REDUCE_SEQUENCER -- requirements
Module: reduce_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of tree sum, accumulator and result.
REQ-002 SHALL have parameter LAYER, default 2: register-stage count of the controlled adder tree.
REQ-003 SHALL have parameter CNT_W, default 8: width of the chunk-count field.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: begin one reduction; sampled only in IDLE.
REQ-007 SHALL have port num_chunks, input, CNT_W: number of input chunks in the reduction; sampled with start.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port in_valid, input, 1: upstream chunk present on the tree's data inputs.
REQ-010 SHALL have port in_ready, output, 1: controller accepts a chunk this cycle.
REQ-011 SHALL have port tree_enable, output, 1: drives the adder tree's shared stage enable.
REQ-012 SHALL have port tree_sum, input, DATA_WIDTH: adder tree output.
REQ-013 SHALL have port out_valid, input/output handshake: out_valid output, 1: result available.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-015 SHALL have port out_data, output, DATA_WIDTH: accumulated reduction result.
REQ-016 SHALL have port done, output, 1: one-cycle pulse after the result handshake.

Function
REQ-017 SHALL implement states IDLE, FEED, DRAIN and OUT.
REQ-018 SHALL, in IDLE with start=1 and num_chunks!=0, clear the accumulator, load the remaining-chunk counter with num_chunks and go to FEED.
REQ-019 SHALL, in IDLE with start=1 and num_chunks=0, set out_data=0 and go directly to OUT.
REQ-020 SHALL ignore start in FEED, DRAIN and OUT.
REQ-021 SHALL drive in_ready=1 only in FEED; a chunk is accepted when in_valid and in_ready are both high.
REQ-022 SHALL drive tree_enable=1 in FEED and DRAIN and 0 in IDLE and OUT.
REQ-023 SHALL keep a LAYER-bit tag shift register advancing on every cycle with tree_enable=1; tag[0] loads 1 on an accepted chunk and 0 on a bubble.
REQ-024 SHALL add tree_sum into the accumulator on each cycle where tag[LAYER-1]=1 and tree_enable=1; the sum wraps modulo 2^DATA_WIDTH.
REQ-025 SHALL decrement the remaining-chunk counter on each accepted chunk and go to DRAIN on acceptance of the last chunk.
REQ-026 SHALL, in DRAIN, go to OUT on the edge that performs the accumulation of the final tagged chunk; out_valid first rises LAYER+1 cycles after the last accept cycle.
REQ-027 SHALL, in OUT, hold out_valid=1 and out_data stable until out_ready=1, then go to IDLE and pulse done for exactly one cycle.
REQ-028 SHALL tolerate in_valid gaps in FEED (bubbles) with no effect on the result beyond latency.
REQ-029 SHALL never accumulate untagged tree_sum values, including stale tree contents left from a previous run.
REQ-030 SHALL accept a new start in the cycle that done is high, since the state is already IDLE.

Reset
REQ-031 SHALL, while rst=0, immediately force state=IDLE, busy=0, in_ready=0, tree_enable=0, out_valid=0, out_data=0, done=0, tags=0, accumulator=0 and counter=0.
REQ-032 SHALL abandon any reduction in progress on reset, with no result emitted.

Verification
REQ-033 SHALL cover the following scenario, with LAYER=2: start with num_chunks=3; chunks accepted on consecutive cycles with tree_sum values 5, 7, 9 -> out_valid rises 3 cycles after the third accept, out_data=21, and done pulses once after out_ready.
REQ-034 SHALL cover the following scenario: num_chunks=4, with in_valid low for 2 cycles between chunks 2 and 3 -> the sum is identical to the gapless run and only the latency increases by 2.
REQ-035 SHALL cover the following scenario: DATA_WIDTH=32, tree_sums 0xFFFFFFFF and 0x00000002 -> out_data=0x00000001.
REQ-036 SHALL cover the following scenario: start with num_chunks=0 -> out_valid next cycle, out_data=0, tree_enable never high.
REQ-037 SHALL cover the following scenario: out_ready held low for 5 cycles in OUT -> out_valid and out_data stable, tree_enable=0, start ignored.
REQ-038 SHALL cover the following scenario: rst asserted in DRAIN -> all outputs zero immediately; a following run with num_chunks=1 and value 4 -> out_data=4.
